// File: rtl/nandy_io_pkg.sv
// Shared register-map constants and helpers for the CPU I/O port responder.
// Status byte layout: {ie_sig, ie_rx, count[2:0], tx_ovf, tx_valid, !empty}.
package nandy_io_pkg;

    // Register select encodings
    localparam logic [1:0] RS_RXTX = 2'd0;
    localparam logic [1:0] RS_STAT = 2'd1;
    localparam logic [1:0] RS_PORT = 2'd2;
    localparam logic [1:0] RS_SIG  = 2'd3;

    // Status bit positions; ST_CNT is the LSB of the 3-bit saturated count field
    localparam int unsigned ST_NEMPTY = 0;
    localparam int unsigned ST_TXV    = 1;
    localparam int unsigned ST_TXOVF  = 2;
    localparam int unsigned ST_CNT    = 3;
    localparam int unsigned ST_IERX   = 6;
    localparam int unsigned ST_IESIG  = 7;

    // Count field is only 3 bits wide; deeper FIFOs report 7 once they hold 7 or more
    function automatic logic [2:0] sat_count(input logic [4:0] cnt);
        return (cnt > 5'd7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Receive FIFO for the I/O port responder. DEPTH must be a power of two so
// pointer wrap is the natural binary overflow. Push and pop on one edge both
// take effect with the count unchanged.
module io_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // Guard against overflow/underflow even if the caller does not
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next-state pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are meaningless after reset since count is zero
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_port_responder.sv
// Peripheral-side responder for the CPU I/O strobes. Four-register map:
// RX FIFO / TX holding register, status, output latch and sticky SIG flags.
// Define IO_IRQ_EN to add the interrupt-enable bits and the registered irq output.
module io_port_responder
    import nandy_io_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 4,
    parameter logic [7:0]  SIG_MASK = 8'hFF
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       RD,
    input  logic       WR,
    input  logic [1:0] RS,
    input  logic [7:0] nSIG,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
`ifdef IO_IRQ_EN
    output logic       irq,
`endif
    output logic [7:0] port_out
);

    localparam int unsigned CntW = $clog2(RX_DEPTH + 1);

    logic [7:0]      rx_head;
    logic            rx_empty, rx_full, rx_push, rx_pop;
    logic [CntW-1:0] rx_count;
    logic [4:0]      cnt_ext;

    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic [7:0] port_q, port_d;
    logic [7:0] sig_flags_q, sig_flags_d;
    logic       ie_rx, ie_sig;
    logic [7:0] status;

    logic wr_rxtx, wr_stat, wr_port, wr_sig;

    assign wr_rxtx = WR && (RS == RS_RXTX);
    assign wr_stat = WR && (RS == RS_STAT);
    assign wr_port = WR && (RS == RS_PORT);
    assign wr_sig  = WR && (RS == RS_SIG);

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = RD && (RS == RS_RXTX) && !rx_empty;
    assign cnt_ext  = 5'(rx_count);

    io_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

`ifdef IO_IRQ_EN
    logic [1:0] ie_q, ie_d;
    logic       irq_q, irq_d;

    // Enable bits from status writes; irq follows its sources by one cycle
    always_comb begin
        ie_d  = ie_q;
        if (wr_stat) ie_d = cpu_dout[1:0];
        irq_d = (ie_q[0] && !rx_empty) || (ie_q[1] && (|sig_flags_q));
    end

    // Interrupt state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie_rx  = ie_q[0];
    assign ie_sig = ie_q[1];
    assign irq    = irq_q;
`else
    assign ie_rx  = 1'b0;
    assign ie_sig = 1'b0;
`endif

    // Next state for TX holding register, overflow flag, port latch and SIG flags
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_ovf_d   = tx_ovf_q;
        port_d     = port_q;
        // A byte drained on this edge frees the slot for a same-edge write
        if (wr_rxtx && (!tx_valid_q || tx_ready)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = cpu_dout;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (wr_stat && cpu_dout[7]) tx_ovf_d = 1'b0;
        // Set after clear so a same-edge drop wins
        if (wr_rxtx && tx_valid_q && !tx_ready) tx_ovf_d = 1'b1;
        if (wr_port) port_d = cpu_dout;
        // W1C then set, so a new strobe on the clearing edge survives
        sig_flags_d = sig_flags_q & ~(wr_sig ? cpu_dout : 8'h00);
        sig_flags_d = sig_flags_d | (~nSIG & SIG_MASK);
    end

    // Register state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_ovf_q    <= 1'b0;
            port_q      <= 8'h00;
            sig_flags_q <= 8'h00;
        end else begin
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_ovf_q    <= tx_ovf_d;
            port_q      <= port_d;
            sig_flags_q <= sig_flags_d;
        end
    end

    // Zero-latency read mux over pre-edge state
    always_comb begin
        status               = 8'h00;
        status[ST_NEMPTY]    = !rx_empty;
        status[ST_TXV]       = tx_valid_q;
        status[ST_TXOVF]     = tx_ovf_q;
        status[ST_CNT +: 3]  = sat_count(cnt_ext);
        status[ST_IERX]      = ie_rx;
        status[ST_IESIG]     = ie_sig;
        case (RS)
            RS_RXTX: cpu_din = rx_empty ? 8'h00 : rx_head;
            RS_STAT: cpu_din = status;
            RS_PORT: cpu_din = port_q;
            RS_SIG:  cpu_din = sig_flags_q;
            default: cpu_din = 8'h00;
        endcase
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign port_out = port_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed scenarios then random
// traffic, all checked against a queue-based register-map model.
module tb_io_port_responder;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  MASK  = 8'hFF;

    logic       clk, nrst;
    logic       RD, WR, rx_valid, tx_ready;
    logic [1:0] RS;
    logic [7:0] nSIG, cpu_dout, rx_data;
    logic [7:0] cpu_din, tx_data, port_out;
    logic       rx_ready, tx_valid;
`ifdef IO_IRQ_EN
    logic       irq;
`endif

    io_port_responder #(
        .RX_DEPTH (DEPTH),
        .SIG_MASK (MASK)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .RD       (RD),
        .WR       (WR),
        .RS       (RS),
        .nSIG     (nSIG),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
`ifdef IO_IRQ_EN
        .irq      (irq),
`endif
        .port_out (port_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_txv, m_ovf, m_ie_rx, m_ie_sig, m_irq;
    logic [7:0] m_txd, m_port, m_sig;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_txv = 0; m_ovf = 0; m_ie_rx = 0; m_ie_sig = 0; m_irq = 0;
        m_txd = 0; m_port = 0; m_sig = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [1:0] rs);
        int n;
        n = (m_q.size() > 7) ? 7 : m_q.size();
        case (rs)
            2'd0: return (m_q.size() == 0) ? 8'h00 : m_q[0];
            2'd1: return {m_ie_sig, m_ie_rx, 3'(n), m_ovf, m_txv, m_q.size() != 0};
            2'd2: return m_port;
            default: return m_sig;
        endcase
    endfunction

    task automatic m_edge(input logic rd, input logic wr, input logic [1:0] rs,
                          input logic [7:0] dout, input logic [7:0] nsig,
                          input logic rxv, input logic [7:0] rxd, input logic txr);
        logic room;
        room = (m_q.size() < DEPTH);
`ifdef IO_IRQ_EN
        m_irq = (m_ie_rx && m_q.size() != 0) || (m_ie_sig && m_sig != 0);
        if (wr && rs == 2'd1) begin
            m_ie_rx  = dout[0];
            m_ie_sig = dout[1];
        end
`endif
        if (rd && rs == 2'd0 && m_q.size() != 0) void'(m_q.pop_front());
        if (rxv && room) m_q.push_back(rxd);
        if (wr && rs == 2'd1 && dout[7]) m_ovf = 0;
        if (wr && rs == 2'd0) begin
            if (!m_txv || txr) begin
                m_txv = 1;
                m_txd = dout;
            end else begin
                m_ovf = 1;
            end
        end else if (m_txv && txr) begin
            m_txv = 0;
        end
        if (wr && rs == 2'd2) m_port = dout;
        if (wr && rs == 2'd3) m_sig = m_sig & ~dout;
        m_sig = m_sig | (~nsig & MASK);
    endtask

    // One clock: drive at posedge+1, check pre-edge outputs, advance model and clock
    task automatic cyc(input logic rd, input logic wr, input logic [1:0] rs,
                       input logic [7:0] dout, input logic [7:0] nsig,
                       input logic rxv, input logic [7:0] rxd, input logic txr,
                       output logic [7:0] din_o);
        RD = rd; WR = wr; RS = rs; cpu_dout = dout; nSIG = nsig;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        #1;
        din_o = cpu_din;
        chk("cpu_din", cpu_din, m_read(rs));
        chk("rx_ready", {7'd0, rx_ready}, {7'd0, m_q.size() < DEPTH});
        chk("tx_valid", {7'd0, tx_valid}, {7'd0, m_txv});
        chk("tx_data", tx_data, m_txd);
        chk("port_out", port_out, m_port);
`ifdef IO_IRQ_EN
        chk("irq", {7'd0, irq}, {7'd0, m_irq});
`endif
        m_edge(rd, wr, rs, dout, nsig, rxv, rxd, txr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic txr);
        logic [7:0] d;
        cyc(0, 0, 2'd0, 8'h00, 8'hFF, 0, 8'h00, txr, d);
    endtask

    logic [7:0] d;
    logic [7:0] pat [4];

    initial begin
        pat[0] = 8'h5A; pat[1] = 8'hA5; pat[2] = 8'h3C; pat[3] = 8'hC3;
        RD = 0; WR = 0; RS = 0; cpu_dout = 0; nSIG = 8'hFF;
        rx_valid = 0; rx_data = 0; tx_ready = 0;
        nrst = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 nrst = 1;

        // Reset state and empty-FIFO read
        cyc(1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("rst_status", d, 8'h00);
        cyc(1, 0, 2'd0, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("rst_rx_empty", d, 8'h00);
        chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        chk("rst_port", port_out, 8'h00);

        // Fill the FIFO, check full and status, drain in order
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'd1, 8'h00, 8'hFF, 1, pat[i], 0, d);
        chk("full_rx_ready", {7'd0, rx_ready}, 8'h00);
        cyc(1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("full_status", d, 8'h21);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 2'd0, 8'h00, 8'hFF, 0, 8'h00, 0, d);
            chk("rx_order", d, pat[i]);
        end
        cyc(1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("drained_status", d, 8'h00);

        // TX accept, overflow drop, drain, overflow clear
        cyc(0, 1, 2'd0, 8'h77, 8'hFF, 0, 8'h00, 0, d);
        chk("tx_v1", {7'd0, tx_valid}, 8'h01);
        chk("tx_d1", tx_data, 8'h77);
        cyc(0, 1, 2'd0, 8'h88, 8'hFF, 0, 8'h00, 0, d);
        chk("tx_keep", tx_data, 8'h77);
        cyc(1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("tx_ovf_set", d & 8'h04, 8'h04);
        idle(1);
        chk("tx_drained", {7'd0, tx_valid}, 8'h00);
        cyc(0, 1, 2'd1, 8'h80, 8'hFF, 0, 8'h00, 0, d);
        cyc(1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("tx_ovf_clr", d & 8'h04, 8'h00);

        // SIG capture, set-beats-clear, then clear
        idle(0);
        cyc(0, 0, 2'd3, 8'h00, 8'hFB, 0, 8'h00, 0, d);
        cyc(1, 0, 2'd3, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("sig_set", d, 8'h04);
        cyc(0, 1, 2'd3, 8'h04, 8'hFB, 0, 8'h00, 0, d);
        cyc(1, 0, 2'd3, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("sig_set_wins", d, 8'h04);
        cyc(0, 1, 2'd3, 8'h04, 8'hFF, 0, 8'h00, 0, d);
        cyc(1, 0, 2'd3, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("sig_clr", d, 8'h00);

        // Simultaneous push and pop at count 2
        cyc(0, 0, 2'd1, 8'h00, 8'hFF, 1, 8'h11, 0, d);
        cyc(0, 0, 2'd1, 8'h00, 8'hFF, 1, 8'h22, 0, d);
        cyc(1, 0, 2'd0, 8'h00, 8'hFF, 1, 8'h33, 0, d);
        chk("pushpop_head", d, 8'h11);
        cyc(1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("pushpop_cnt", (d >> 3) & 8'h07, 8'h02);

        // RD&WR on the port latch: read shows old value
        cyc(0, 1, 2'd2, 8'h11, 8'hFF, 0, 8'h00, 0, d);
        cyc(1, 1, 2'd2, 8'h22, 8'hFF, 0, 8'h00, 0, d);
        chk("rdwr_old", d, 8'h11);
        chk("rdwr_new", port_out, 8'h22);

        // Drain leftovers
        for (int i = 0; i < 2; i++) cyc(1, 0, 2'd0, 8'h00, 8'hFF, 0, 8'h00, 0, d);

`ifdef IO_IRQ_EN
        cyc(0, 1, 2'd1, 8'h01, 8'hFF, 0, 8'h00, 0, d);
        cyc(0, 0, 2'd1, 8'h00, 8'hFF, 1, 8'h9E, 0, d);
        chk("irq_lag", {7'd0, irq}, 8'h00);
        idle(0);
        chk("irq_set", {7'd0, irq}, 8'h01);
        cyc(1, 0, 2'd0, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        idle(0);
        chk("irq_clr", {7'd0, irq}, 8'h00);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ns;
            ns = ($urandom_range(0, 3) == 0) ? ~(8'h01 << $urandom_range(0, 7)) : 8'hFF;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                8'($urandom), ns, $urandom_range(0, 1) == 1, 8'($urandom),
                $urandom_range(0, 3) == 0, d);
        end

        // Async reset while a TX byte is pending and the FIFO holds data
        cyc(0, 1, 2'd1, 8'h03, 8'hFF, 1, 8'h44, 0, d);
        idle(0);
        cyc(0, 1, 2'd0, 8'hAB, 8'hFF, 0, 8'h00, 0, d);
        idle(0);
        chk("pre_rst_txv", {7'd0, tx_valid}, 8'h01);
        #2 nrst = 0;
        #1;
        chk("rst_mid_txv", {7'd0, tx_valid}, 8'h00);
`ifdef IO_IRQ_EN
        chk("rst_mid_irq", {7'd0, irq}, 8'h00);
`endif
        m_reset();
        @(posedge clk);
        #1 nrst = 1;
        cyc(1, 0, 2'd1, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("post_rst_status", d, 8'h00);
        cyc(1, 0, 2'd0, 8'h00, 8'hFF, 0, 8'h00, 0, d);
        chk("post_rst_rx", d, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
